// File: rtl/accelerator_state_gate_vector_if.sv
// rtl/accelerator_state_gate_vector_if.sv - operand/result bundle for the LSTM cell-state update stage
interface accelerator_state_gate_vector_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic [DATA_SIZE-1:0] SIZE_L_IN;

    logic                 F_IN_ENABLE;
    logic                 I_IN_ENABLE;
    logic                 A_IN_ENABLE;
    logic                 S_IN_ENABLE;
    logic [DATA_SIZE-1:0] F_IN;
    logic [DATA_SIZE-1:0] I_IN;
    logic [DATA_SIZE-1:0] A_IN;
    logic [DATA_SIZE-1:0] S_IN;

    logic                 S_OUT_ENABLE;
    logic [DATA_SIZE-1:0] S_OUT;

    // Upstream side: drives operands and control, observes results.
    modport master (
        output START, SIZE_L_IN,
        output F_IN_ENABLE, I_IN_ENABLE, A_IN_ENABLE, S_IN_ENABLE,
        output F_IN, I_IN, A_IN, S_IN,
        input  READY, S_OUT_ENABLE, S_OUT
    );

    // Cell-state stage side.
    modport slave (
        input  START, SIZE_L_IN,
        input  F_IN_ENABLE, I_IN_ENABLE, A_IN_ENABLE, S_IN_ENABLE,
        input  F_IN, I_IN, A_IN, S_IN,
        output READY, S_OUT_ENABLE, S_OUT
    );
endinterface

// File: rtl/accelerator_state_gate_vector.sv
// rtl/accelerator_state_gate_vector.sv - element-wise s = f*s_prev + i*a over an L-element vector
module accelerator_state_gate_vector #(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 4,
    parameter int FRACTION_SIZE = 32
) (
    input  logic CLK,
    input  logic RST,
    accelerator_state_gate_vector_if.slave bus
);

    // CONTROL_SIZE exists only so every accelerator stage shares one parameter list.
    if (CONTROL_SIZE < 1) begin : g_control_size_unused
    end

    typedef enum logic [1:0] {
        STARTER_STATE,
        INPUT_STATE,
        PRODUCT_STATE,
        ADDER_STATE
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] size_l;
    logic [DATA_SIZE-1:0] index;

    logic [DATA_SIZE-1:0] f_data;
    logic [DATA_SIZE-1:0] i_data;
    logic [DATA_SIZE-1:0] a_data;
    logic [DATA_SIZE-1:0] s_data;
    logic                 f_flag;
    logic                 i_flag;
    logic                 a_flag;
    logic                 s_flag;

    logic [DATA_SIZE-1:0] p_f;
    logic [DATA_SIZE-1:0] p_i;

    logic                 ready_q;
    logic                 s_out_enable_q;
    logic [DATA_SIZE-1:0] s_out_q;

    logic                 all_operands;
    logic                 last_element;

    // Fixed-point multiply: full-width signed product, floor shift by the
    // fraction width, keep the low DATA_SIZE bits (wraps on overflow).
    function automatic logic [DATA_SIZE-1:0] fx_mul(
        input logic signed [DATA_SIZE-1:0] x,
        input logic signed [DATA_SIZE-1:0] y
    );
        logic signed [2*DATA_SIZE-1:0] prod;
        prod = x * y;
        return prod[FRACTION_SIZE +: DATA_SIZE];
    endfunction

    // An operand counts as present if already flagged or arriving this cycle.
    assign all_operands = (f_flag | bus.F_IN_ENABLE) & (i_flag | bus.I_IN_ENABLE) &
                          (a_flag | bus.A_IN_ENABLE) & (s_flag | bus.S_IN_ENABLE);
    assign last_element = (index == size_l - DATA_SIZE'(1));

    assign bus.READY        = ready_q;
    assign bus.S_OUT_ENABLE = s_out_enable_q;
    assign bus.S_OUT        = s_out_q;

    // Sequencer: start -> collect four operands -> multiply -> add/emit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= STARTER_STATE;
            size_l         <= '0;
            index          <= '0;
            f_data         <= '0;
            i_data         <= '0;
            a_data         <= '0;
            s_data         <= '0;
            f_flag         <= 1'b0;
            i_flag         <= 1'b0;
            a_flag         <= 1'b0;
            s_flag         <= 1'b0;
            p_f            <= '0;
            p_i            <= '0;
            ready_q        <= 1'b0;
            s_out_enable_q <= 1'b0;
            s_out_q        <= '0;
        end else begin
            ready_q        <= 1'b0;
            s_out_enable_q <= 1'b0;
            case (state)
                STARTER_STATE: begin
                    if (bus.START) begin
                        size_l <= bus.SIZE_L_IN;
                        index  <= '0;
                        f_flag <= 1'b0;
                        i_flag <= 1'b0;
                        a_flag <= 1'b0;
                        s_flag <= 1'b0;
                        if (bus.SIZE_L_IN == '0) begin
                            ready_q <= 1'b1;
                        end else begin
                            state <= INPUT_STATE;
                        end
                    end
                end
                INPUT_STATE: begin
                    if (bus.F_IN_ENABLE) begin
                        f_data <= bus.F_IN;
                        f_flag <= 1'b1;
                    end
                    if (bus.I_IN_ENABLE) begin
                        i_data <= bus.I_IN;
                        i_flag <= 1'b1;
                    end
                    if (bus.A_IN_ENABLE) begin
                        a_data <= bus.A_IN;
                        a_flag <= 1'b1;
                    end
                    if (bus.S_IN_ENABLE) begin
                        s_data <= bus.S_IN;
                        s_flag <= 1'b1;
                    end
                    if (all_operands) begin
                        state <= PRODUCT_STATE;
                    end
                end
                PRODUCT_STATE: begin
                    p_f    <= fx_mul(f_data, s_data);
                    p_i    <= fx_mul(i_data, a_data);
                    f_flag <= 1'b0;
                    i_flag <= 1'b0;
                    a_flag <= 1'b0;
                    s_flag <= 1'b0;
                    state  <= ADDER_STATE;
                end
                ADDER_STATE: begin
                    s_out_q        <= p_f + p_i;
                    s_out_enable_q <= 1'b1;
                    if (last_element) begin
                        ready_q <= 1'b1;
                        state   <= STARTER_STATE;
                    end else begin
                        index <= index + DATA_SIZE'(1);
                        state <= INPUT_STATE;
                    end
                end
                default: state <= STARTER_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator_state_gate_vector.sv
// tb/tb_accelerator_state_gate_vector.sv - directed self-checking bench for the cell-state update stage
module tb_accelerator_state_gate_vector;

    localparam int DW = 16;
    localparam int FW = 8;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    accelerator_state_gate_vector_if #(.DATA_SIZE(DW)) bus ();

    accelerator_state_gate_vector #(
        .DATA_SIZE    (DW),
        .CONTROL_SIZE (4),
        .FRACTION_SIZE(FW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [DW-1:0] len);
        bus.START     = 1'b1;
        bus.SIZE_L_IN = len;
        step();
        bus.START     = 1'b0;
    endtask

    // Present one cycle of operands; a zero enable leaves that lane idle.
    task automatic op(input logic ef, input logic [DW-1:0] f,
                      input logic es, input logic [DW-1:0] s,
                      input logic ei, input logic [DW-1:0] i,
                      input logic ea, input logic [DW-1:0] a);
        bus.F_IN_ENABLE = ef; bus.F_IN = f;
        bus.S_IN_ENABLE = es; bus.S_IN = s;
        bus.I_IN_ENABLE = ei; bus.I_IN = i;
        bus.A_IN_ENABLE = ea; bus.A_IN = a;
        step();
        bus.F_IN_ENABLE = 1'b0;
        bus.S_IN_ENABLE = 1'b0;
        bus.I_IN_ENABLE = 1'b0;
        bus.A_IN_ENABLE = 1'b0;
    endtask

    // Called right after the completing operand edge: result lands exactly two edges later, for one cycle.
    task automatic expect_result(input string tag, input logic [DW-1:0] val, input logic rdy);
        step();
        check({tag, "_lat1_en"}, 64'(bus.S_OUT_ENABLE), 64'd0);
        step();
        check({tag, "_en"},    64'(bus.S_OUT_ENABLE), 64'd1);
        check({tag, "_val"},   64'(bus.S_OUT),        64'(val));
        check({tag, "_ready"}, 64'(bus.READY),        64'(rdy));
        step();
        check({tag, "_en_drop"},    64'(bus.S_OUT_ENABLE), 64'd0);
        check({tag, "_ready_drop"}, 64'(bus.READY),        64'd0);
        check({tag, "_hold"},       64'(bus.S_OUT),        64'(val));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b0;
        bus.START = 1'b0;
        bus.SIZE_L_IN = '0;
        bus.F_IN_ENABLE = 1'b0; bus.I_IN_ENABLE = 1'b0;
        bus.A_IN_ENABLE = 1'b0; bus.S_IN_ENABLE = 1'b0;
        bus.F_IN = '0; bus.I_IN = '0; bus.A_IN = '0; bus.S_IN = '0;

        // Reset state
        step();
        step();
        check("rst_ready", 64'(bus.READY),        64'd0);
        check("rst_en",    64'(bus.S_OUT_ENABLE), 64'd0);
        check("rst_sout",  64'(bus.S_OUT),        64'd0);
        RST = 1'b1;
        step();

        // Basic L=1: 0.5*2.0 + 1.0*0.25 = 1.25
        start(16'd1);
        op(1'b1, 16'h0080, 1'b1, 16'h0200, 1'b1, 16'h0100, 1'b1, 16'h0040);
        expect_result("basic", 16'h0140, 1'b1);

        // Staggered L=3 with F overwrite and a stray START/SIZE change mid-vector
        start(16'd3);
        op(1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        bus.START = 1'b1;
        bus.SIZE_L_IN = 16'd5;
        op(1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000);
        bus.START = 1'b0;
        bus.SIZE_L_IN = 16'd9;
        op(1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        op(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000);
        check("stag0_wait", 64'(bus.S_OUT_ENABLE), 64'd0);
        op(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0200);
        expect_result("stag0", 16'h0280, 1'b0);
        op(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b1, 16'h0100);
        op(1'b0, 16'h0000, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b0, 16'h0000);
        op(1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        expect_result("stag1", 16'h0380, 1'b0);
        op(1'b1, 16'h0040, 1'b1, 16'h0400, 1'b0, 16'h0000, 1'b0, 16'h0000);
        op(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 16'h0080);
        expect_result("stag2", 16'h0200, 1'b1);

        // Floor toward -inf and sign handling, L=2
        start(16'd2);
        op(1'b1, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b1, 16'h0001);
        expect_result("floor", 16'hFFFF, 1'b0);
        op(1'b1, 16'hFF00, 1'b1, 16'h0100, 1'b1, 16'h0000, 1'b1, 16'h0000);
        expect_result("neg", 16'hFF00, 1'b1);

        // Overflow wraps: 127.0 * 2.0
        start(16'd1);
        op(1'b1, 16'h7F00, 1'b1, 16'h0200, 1'b1, 16'h0000, 1'b1, 16'h0000);
        expect_result("wrap", 16'hFE00, 1'b1);

        // L=0: READY one cycle after START, never S_OUT_ENABLE
        start(16'd0);
        check("l0_ready", 64'(bus.READY),        64'd1);
        check("l0_en",    64'(bus.S_OUT_ENABLE), 64'd0);
        step();
        check("l0_ready_drop", 64'(bus.READY), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("l0_no_en", 64'(bus.S_OUT_ENABLE), 64'd0);
            step();
        end

        // Enables during PRODUCT_STATE are dropped, L=2
        start(16'd2);
        op(1'b1, 16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0000, 1'b1, 16'h0000);
        op(1'b1, 16'h0100, 1'b1, 16'h0500, 1'b1, 16'h0000, 1'b1, 16'h0000);
        check("drop_lat_en", 64'(bus.S_OUT_ENABLE), 64'd0);
        step();
        check("drop0_en",  64'(bus.S_OUT_ENABLE), 64'd1);
        check("drop0_val", 64'(bus.S_OUT),        64'h0100);
        check("drop0_rdy", 64'(bus.READY),        64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("drop_wait_en", 64'(bus.S_OUT_ENABLE), 64'd0);
        end
        op(1'b1, 16'h0200, 1'b1, 16'h0300, 1'b1, 16'h0100, 1'b1, 16'h0100);
        expect_result("drop1", 16'h0700, 1'b1);

        // Asynchronous reset in PRODUCT_STATE aborts the vector
        start(16'd1);
        op(1'b1, 16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0100);
        RST = 1'b0;
        #1;
        check("arst_ready", 64'(bus.READY),        64'd0);
        check("arst_en",    64'(bus.S_OUT_ENABLE), 64'd0);
        check("arst_sout",  64'(bus.S_OUT),        64'd0);
        step();
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("arst_no_en",    64'(bus.S_OUT_ENABLE), 64'd0);
            check("arst_no_ready", 64'(bus.READY),        64'd0);
        end
        start(16'd1);
        op(1'b1, 16'h0100, 1'b1, 16'h0300, 1'b1, 16'h0040, 1'b1, 16'h0400);
        expect_result("post_rst", 16'h0400, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
